// File: rtl/alu_main_dec.sv
// Main control FSM for the multicycle MIPS datapath (Moore machine).
// Latency: outputs follow state combinationally; state advances on each rising clk.
// Backpressure: none; one state step per clock. Optional ori path under ORI_SUPPORT_EN.
module alu_main_dec (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Opcode,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       IorD,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic       RegWrite,
  output logic [1:0] ALUOp
);

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef ORI_SUPPORT_EN
  localparam logic [5:0] OP_ORI  = 6'b001101;
`endif

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
`ifdef ORI_SUPPORT_EN
    S_JEX     = 4'd11,
    S_ORIEX   = 4'd12
`else
    S_JEX     = 4'd11
`endif
  } state_t;

  state_t r_state;
  state_t w_next;

  // State register; reset low forces FETCH immediately and holds it there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state selection; unknown opcodes and illegal codes fall back to FETCH.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYP:      w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQEX;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JEX;
`ifdef ORI_SUPPORT_EN
          OP_ORI:       w_next = S_ORIEX;
`endif
          default:      w_next = S_FETCH;
        endcase
      end
      // Opcode is looked at again here to split loads from stores.
      S_MEMADR:  w_next = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next = S_MEMWB;
      S_MEMWB:   w_next = S_FETCH;
      S_MEMWR:   w_next = S_FETCH;
      S_RTYPEEX: w_next = S_RTYPEWB;
      S_RTYPEWB: w_next = S_FETCH;
      S_BEQEX:   w_next = S_FETCH;
      S_ADDIEX:  w_next = S_ADDIWB;
      S_ADDIWB:  w_next = S_FETCH;
      S_JEX:     w_next = S_FETCH;
`ifdef ORI_SUPPORT_EN
      // ori shares the immediate writeback state with addi.
      S_ORIEX:   w_next = S_ADDIWB;
`endif
      default:   w_next = S_FETCH;
    endcase
  end

  // Moore outputs decoded from state only; everything defaults to 0.
  always_comb begin
    MemtoReg = 1'b0;
    RegDst   = 1'b0;
    IorD     = 1'b0;
    PCSrc    = 2'b00;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    IRWrite  = 1'b0;
    MemWrite = 1'b0;
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    RegWrite = 1'b0;
    ALUOp    = 2'b00;
    case (r_state)
      S_FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_RTYPEEX: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RTYPEWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BEQEX: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        Branch  = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_JEX: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
      end
`ifdef ORI_SUPPORT_EN
      S_ORIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b11;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_main_dec.sv
// Directed bench for alu_main_dec: instruction-level model plus literal per-step checks.
module tb_alu_main_dec;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] Opcode = 6'b001000;
  logic       MemtoReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite, PCWrite, Branch, RegWrite;
  logic [1:0] PCSrc, ALUSrcB, ALUOp;

  int tests = 0;
  int fails = 0;
  bit done  = 1'b0;

  alu_main_dec dut (
    .clk(clk), .rst(rst), .Opcode(Opcode),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .IorD(IorD), .PCSrc(PCSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .PCWrite(PCWrite), .Branch(Branch), .RegWrite(RegWrite), .ALUOp(ALUOp)
  );

  always #5 clk = ~clk;

  // Output bundle: {MemtoReg,RegDst,IorD,PCSrc,ALUSrcA,ALUSrcB,IRWrite,MemWrite,PCWrite,Branch,RegWrite,ALUOp}
  logic [14:0] dut_v;
  assign dut_v = {MemtoReg, RegDst, IorD, PCSrc, ALUSrcA, ALUSrcB,
                  IRWrite, MemWrite, PCWrite, Branch, RegWrite, ALUOp};

  localparam logic [14:0] V_FETCH = 15'b0_0_0_00_0_01_1_0_1_0_0_00;
  localparam logic [14:0] V_DEC   = 15'b0_0_0_00_0_11_0_0_0_0_0_00;
  localparam logic [14:0] V_ADR   = 15'b0_0_0_00_1_10_0_0_0_0_0_00;
  localparam logic [14:0] V_MRD   = 15'b0_0_1_00_0_00_0_0_0_0_0_00;
  localparam logic [14:0] V_MWB   = 15'b1_0_0_00_0_00_0_0_0_0_1_00;
  localparam logic [14:0] V_MWR   = 15'b0_0_1_00_0_00_0_1_0_0_0_00;
  localparam logic [14:0] V_REX   = 15'b0_0_0_00_1_00_0_0_0_0_0_10;
  localparam logic [14:0] V_RWB   = 15'b0_1_0_00_0_00_0_0_0_0_1_00;
  localparam logic [14:0] V_BEQ   = 15'b0_0_0_01_1_00_0_0_0_1_0_01;
  localparam logic [14:0] V_AEX   = 15'b0_0_0_00_1_10_0_0_0_0_0_00;
  localparam logic [14:0] V_AWB   = 15'b0_0_0_00_0_00_0_0_0_0_1_00;
  localparam logic [14:0] V_JEX   = 15'b0_0_0_10_0_00_0_0_1_0_0_00;
  localparam logic [14:0] V_ORI   = 15'b0_0_0_00_1_10_0_0_0_0_0_11;

  // Instruction classes for the model
  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_BEQ = 3, C_ADDI = 4, C_J = 5, C_UNK = 6, C_ORI = 7;

  function automatic int cls_of(input logic [5:0] op);
    case (op)
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000000: return C_R;
      6'b000100: return C_BEQ;
      6'b001000: return C_ADDI;
      6'b000010: return C_J;
`ifdef ORI_SUPPORT_EN
      6'b001101: return C_ORI;
`endif
      default:   return C_UNK;
    endcase
  endfunction

  // Cycles per instruction, FETCH included
  function automatic int len_of(input int c);
    case (c)
      C_LW: return 5;
      C_SW, C_R, C_ADDI, C_ORI: return 4;
      C_BEQ, C_J: return 3;
      default: return 2;
    endcase
  endfunction

  // Expected outputs at a given step of a given instruction class
  function automatic logic [14:0] exp_out(input int c, input int step);
    logic [14:0] seq [5];
    seq[0] = V_FETCH;
    seq[1] = V_DEC;
    seq[2] = 15'd0; seq[3] = 15'd0; seq[4] = 15'd0;
    case (c)
      C_LW:   begin seq[2] = V_ADR; seq[3] = V_MRD; seq[4] = V_MWB; end
      C_SW:   begin seq[2] = V_ADR; seq[3] = V_MWR; end
      C_R:    begin seq[2] = V_REX; seq[3] = V_RWB; end
      C_BEQ:  seq[2] = V_BEQ;
      C_ADDI: begin seq[2] = V_AEX; seq[3] = V_AWB; end
      C_J:    seq[2] = V_JEX;
      C_ORI:  begin seq[2] = V_ORI; seq[3] = V_AWB; end
      default: ;
    endcase
    if (step < 0 || step > 4) return 15'h7fff;
    return seq[step];
  endfunction

  // Model: position within the current instruction
  int m_step = 0;
  int m_cls  = C_UNK;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_step = 0;
    end else begin
      if (m_step == 1) m_cls = cls_of(Opcode);
      if (m_step == 2 && (m_cls == C_LW || m_cls == C_SW))
        m_cls = (Opcode == 6'b100011) ? C_LW : C_SW;
      m_step = m_step + 1;
      if (m_step >= len_of(m_cls)) m_step = 0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (!done) begin
      tests++;
      if (dut_v !== exp_out(m_cls, m_step)) begin
        fails++;
        $display("FAIL model t=%0t step=%0d cls=%0d: got %b, want %b",
                 $time, m_step, m_cls, dut_v, exp_out(m_cls, m_step));
      end
    end
  end

  task automatic chk(input string name, input logic [14:0] exp);
    tests++;
    if (dut_v !== exp) begin
      fails++;
      $display("FAIL %s: got %b, want %b", name, dut_v, exp);
    end
  endtask

  task automatic step_chk(input string name, input logic [14:0] exp);
    @(posedge clk);
    #1;
    chk(name, exp);
  endtask

  initial begin
    // Reset held with addi on the opcode bus
    #3;
    chk("reset_fetch", V_FETCH);
    #9;
    rst = 1'b1;
    chk("fetch_after_release", V_FETCH);

    // addi
    step_chk("addi_dec", V_DEC);
    step_chk("addi_ex", V_AEX);
    step_chk("addi_wb", V_AWB);
    step_chk("addi_fetch", V_FETCH);

    // lw
    Opcode = 6'b100011;
    step_chk("lw_dec", V_DEC);
    step_chk("lw_adr", V_ADR);
    step_chk("lw_rd", V_MRD);
    step_chk("lw_wb", V_MWB);
    step_chk("lw_fetch", V_FETCH);

    // sw
    Opcode = 6'b101011;
    step_chk("sw_dec", V_DEC);
    step_chk("sw_adr", V_ADR);
    step_chk("sw_wr", V_MWR);
    step_chk("sw_fetch", V_FETCH);

    // R-type
    Opcode = 6'b000000;
    step_chk("r_dec", V_DEC);
    step_chk("r_ex", V_REX);
    step_chk("r_wb", V_RWB);
    step_chk("r_fetch", V_FETCH);

    // beq
    Opcode = 6'b000100;
    step_chk("beq_dec", V_DEC);
    step_chk("beq_ex", V_BEQ);
    step_chk("beq_fetch", V_FETCH);

    // j
    Opcode = 6'b000010;
    step_chk("j_dec", V_DEC);
    step_chk("j_ex", V_JEX);
    step_chk("j_fetch", V_FETCH);

    // unknown opcode: no-op
    Opcode = 6'b111111;
    step_chk("unk_dec", V_DEC);
    step_chk("unk_fetch", V_FETCH);

    // ori: only decoded when the option is built in
    Opcode = 6'b001101;
    step_chk("ori_dec", V_DEC);
`ifdef ORI_SUPPORT_EN
    step_chk("ori_ex", V_ORI);
    step_chk("ori_wb", V_AWB);
`endif
    step_chk("ori_fetch", V_FETCH);

    // Asynchronous reset while MemWrite is high
    Opcode = 6'b101011;
    step_chk("sw2_dec", V_DEC);
    step_chk("sw2_adr", V_ADR);
    step_chk("sw2_wr", V_MWR);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_fetch", V_FETCH);
    tests++;
    if (MemWrite !== 1'b0) begin
      fails++;
      $display("FAIL async_rst_memwrite: got %b, want 0", MemWrite);
    end
    #2;
    rst = 1'b1;
    step_chk("post_rst_dec", V_DEC);
    step_chk("post_rst_adr", V_ADR);
    step_chk("post_rst_wr", V_MWR);
    step_chk("post_rst_fetch", V_FETCH);

    repeat (2) @(negedge clk);
    #1;
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
